mseq_checker: RTL

MSEQ_CHECKER -- requirements
Module: mseq_checker

---
 rtl/mseq_pkg.sv | 24 ++
 rtl/mseq_parity.sv | 17 +
 rtl/mseq_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mseq_pkg.sv
// Shared definitions for the m-sequence checker and its upstream generator.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
// Contents: FSM state enum, LFSR/lock parameter defaults, saturating counter helper.
package mseq_pkg;

  // Defaults shared with the upstream generator; WIDTH is its phase register length.
  localparam int MSEQ_WIDTH      = 4;
  localparam int MSEQ_LOCK_COUNT = 8;
  localparam int MSEQ_LOSS_ERRS  = 3;
  localparam int MSEQ_WINDOW     = 16;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mseq_parity.sv
// Tap parity for a Fibonacci LFSR: p = XOR of the register bits selected by taps.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: r (register contents), taps (feedback mask), p (predicted/next bit).
module mseq_parity
  import mseq_pkg::*;
#(
  parameter int WIDTH = MSEQ_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] taps,
  output logic             p
);

  assign p = ^(r & taps);

endmodule

// File: rtl/mseq_checker.sv
// Locks onto a serial m-sequence, then flywheels it and counts bit errors.
// Latency: every output is registered; response appears one cycle after the sampling edge.
// Backpressure: none; every bit with bit_valid=1 is consumed, bit_valid=0 holds all state.
// Ports: clk, rst (async, active-high), bit_in/bit_valid (serial input), type_f (taps),
//        err_clr (sync clear of err_cnt), locked, err_pulse, sync_lost, err_cnt[15:0].
module mseq_checker
  import mseq_pkg::*;
#(
  parameter int WIDTH      = MSEQ_WIDTH,      // LFSR length, must be >= 2
  parameter int LOCK_COUNT = MSEQ_LOCK_COUNT,
  parameter int LOSS_ERRS  = MSEQ_LOSS_ERRS,
  parameter int WINDOW     = MSEQ_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [WIDTH-1:0] type_f,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [15:0]      err_cnt
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

  state_t               state, state_n;
  logic [WIDTH-1:0]     r, r_n;
  logic [FILL_W-1:0]    fill, fill_n;
  logic [MATCH_W-1:0]   match, match_n;
  logic [WIN_W-1:0]     win, win_n;
  logic [WERR_W-1:0]    werr, werr_n;
  logic                 err_pulse_n, sync_lost_n, err_inc;
  logic [15:0]          err_cnt_n;

  logic                 p;
  logic                 mismatch;
  logic [WIN_W-1:0]     win_next;
  logic [WERR_W-1:0]    werr_next;

  mseq_parity #(.WIDTH(WIDTH)) u_parity (
    .r    (r),
    .taps (type_f),
    .p    (p)
  );

  assign mismatch  = bit_in ^ p;
  assign win_next  = win + WIN_W'(1);
  assign werr_next = werr + WERR_W'(mismatch);

  always_comb begin
    state_n     = state;
    r_n         = r;
    fill_n      = fill;
    match_n     = match;
    win_n       = win;
    werr_n      = werr;
    err_pulse_n = 1'b0;
    sync_lost_n = 1'b0;
    err_inc     = 1'b0;

    if (bit_valid) begin
      case (state)
        ST_HUNT: begin
          r_n = {bit_in, r[WIDTH-1:1]};
          if (fill == FILL_W'(WIDTH - 1)) begin
            state_n = ST_CHECK;
            fill_n  = '0;
            match_n = '0;
          end else begin
            fill_n = fill + FILL_W'(1);
          end
        end

        ST_CHECK: begin
          r_n = {bit_in, r[WIDTH-1:1]};
          // An all-zero register predicts zeros forever; refuse it so a dead line never locks.
          if ((r == '0) || mismatch) begin
            state_n = ST_HUNT;
            fill_n  = '0;
          end else if (match == MATCH_W'(LOCK_COUNT - 1)) begin
            state_n = ST_LOCKED;
            win_n   = '0;
            werr_n  = '0;
          end else begin
            match_n = match + MATCH_W'(1);
          end
        end

        ST_LOCKED: begin
          // Flywheel: feed back our own prediction so line errors cannot corrupt the phase.
          r_n         = {p, r[WIDTH-1:1]};
          err_pulse_n = mismatch;
          err_inc     = mismatch;
          if (werr_next == WERR_W'(LOSS_ERRS)) begin
            state_n     = ST_HUNT;
            fill_n      = '0;
            sync_lost_n = 1'b1;
            win_n       = '0;
            werr_n      = '0;
          end else if (win_next == WIN_W'(WINDOW)) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win_next;
            werr_n = werr_next;
          end
        end

        default: begin
          state_n = ST_HUNT;
          fill_n  = '0;
        end
      endcase
    end
  end

  // Clear has priority over a coincident error increment.
  always_comb begin
    err_cnt_n = err_cnt;
    if (err_clr) begin
      err_cnt_n = '0;
    end else if (err_inc) begin
      err_cnt_n = sat_inc16(err_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HUNT;
      r         <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      fill      <= fill_n;
      match     <= match_n;
      win       <= win_n;
      werr      <= werr_n;
      locked    <= (state_n == ST_LOCKED);
      err_pulse <= err_pulse_n;
      sync_lost <= sync_lost_n;
      err_cnt   <= err_cnt_n;
    end
  end

endmodule
